// File: rtl/sys_cfg_bram_master.sv
// Command-to-BRAM-port initiator for the system register block.
// Define SYS_CFG_MST_WR_VERIFY_EN to read back and check every bus write.
module sys_cfg_bram_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_NUM   = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [BYTE_NUM-1:0]   cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  bram_en,
    output logic [BYTE_NUM-1:0]   bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTE_NUM - 1);
    localparam logic [1:0]            CNT_LAST   = 2'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RWAIT,
        S_RSP
    } state_t;

    state_t state;
    state_t state_d;

    logic [1:0] cnt;
    logic       cnt_done;
    logic       accept;
    logic       unaligned;

    logic                  cmd_ready_d;
    logic                  rsp_valid_d;
    logic                  bram_en_d;
    logic [BYTE_NUM-1:0]   bram_we_d;
    logic [ADDR_WIDTH-1:0] bram_addr_d;
    logic [DATA_WIDTH-1:0] bram_din_d;

    assign accept    = cmd_valid && cmd_ready;
    assign unaligned = |(cmd_addr & ALIGN_MASK);
    assign cnt_done  = (cnt == CNT_LAST);

`ifdef SYS_CFG_MST_WR_VERIFY_EN
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BYTE_NUM-1:0]   wstrb_q;
    logic [DATA_WIDTH-1:0] vmask;
    logic                  verify_bad;

    always_comb begin
        vmask = '0;
        for (int b = 0; b < BYTE_NUM; b++) begin
            vmask[8*b +: 8] = {8{wstrb_q[b]}};
        end
    end

    assign verify_bad = wr_q && (|((bram_dout ^ wdata_q) & vmask));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept) begin
            wr_q    <= cmd_wr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
        end
    end
`endif

    // State register; every output is registered from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            bram_en   <= 1'b0;
            bram_we   <= '0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else begin
            state     <= state_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            bram_en   <= bram_en_d;
            bram_we   <= bram_we_d;
            bram_addr <= bram_addr_d;
            bram_din  <= bram_din_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (unaligned) begin
                        state_d = S_RSP;
                    end else if (cmd_wr) begin
                        state_d = (cmd_wstrb == '0) ? S_RSP : S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
`ifdef SYS_CFG_MST_WR_VERIFY_EN
            S_WR:    state_d = S_RD;
`else
            S_WR:    state_d = S_RSP;
`endif
            S_RD:    state_d = S_RWAIT;
            S_RWAIT: if (cnt_done) state_d = S_RSP;
            S_RSP:   if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // WR is only reached from IDLE, so command fields feed the bus directly.
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RSP);
        bram_en_d   = (state_d == S_WR) || (state_d == S_RD);
        bram_we_d   = '0;
        bram_addr_d = bram_addr;
        bram_din_d  = bram_din;
        if ((state == S_IDLE) && bram_en_d) begin
            bram_addr_d = cmd_addr;
            if (cmd_wr) begin
                bram_din_d = cmd_wdata;
            end
        end
        if (state_d == S_WR) begin
            bram_we_d = cmd_wstrb;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                rsp_rdata <= '0;
                rsp_err   <= unaligned;
            end
            if (state == S_RD) begin
                cnt <= '0;
            end else if (state == S_RWAIT) begin
                cnt <= cnt + 2'd1;
            end
            if ((state == S_RWAIT) && cnt_done) begin
                rsp_rdata <= bram_dout;
`ifdef SYS_CFG_MST_WR_VERIFY_EN
                rsp_err   <= verify_bad;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sys_cfg_bram_master.sv
// Scoreboard bench for sys_cfg_bram_master with a latency-2 BRAM model.
// Honours SYS_CFG_MST_WR_VERIFY_EN for write expectations.
module tb_sys_cfg_bram_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BN  = 4;
    localparam int LAT = 2;
`ifdef SYS_CFG_MST_WR_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [BN-1:0] cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          bram_en;
    logic [BN-1:0] bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;

    always #5 clk = ~clk;

    sys_cfg_bram_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BYTE_NUM  (BN),
        .RD_LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr   (cmd_wr),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .bram_en  (bram_en),
        .bram_we  (bram_we),
        .bram_addr(bram_addr),
        .bram_din (bram_din),
        .bram_dout(bram_dout)
    );

    // BRAM model: read-first, LAT-stage output pipe, optional broken lane 0
    logic [DW-1:0] mem [16] = '{default: '0};
    logic [DW-1:0] pipe [LAT] = '{default: '0};
    logic          ignore_lane0 = 1'b0;

    always @(posedge clk) begin
        if (bram_en) begin
            for (int b = 0; b < BN; b++) begin
                if (bram_we[b] && !(ignore_lane0 && b == 0))
                    mem[bram_addr[5:2]][8*b +: 8] <= bram_din[8*b +: 8];
            end
            pipe[0] <= mem[bram_addr[5:2]];
        end
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bram_dout = pipe[LAT-1];

    typedef struct {
        string         nm;
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        int            acc;
        int            n_en;
        logic [BN-1:0] we;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Monitor: bus activity plus response scoreboard
    int            en_cnt = 0;
    bit            seen = 1'b0;
    logic [BN-1:0] f_we = '0;
    logic [AW-1:0] f_addr = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            en_cnt = 0;
            seen   = 1'b0;
        end else begin
            if (bram_en) begin
                if (en_cnt == 0) begin
                    f_we   = bram_we;
                    f_addr = bram_addr;
                end
                en_cnt++;
            end
            if (rsp_valid) begin
                chk("cmd_ready_during_rsp", 32'(cmd_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk({exp_q[0].nm, "_lat"},
                            32'(cyc - exp_q[0].acc + 1), 32'(exp_q[0].lat));
                    end
                    chk({exp_q[0].nm, "_rdata"}, rsp_rdata, exp_q[0].rdata);
                    chk({exp_q[0].nm, "_err"}, 32'(rsp_err), 32'(exp_q[0].err));
                    if (rsp_ready) begin
                        chk({exp_q[0].nm, "_n_en"}, 32'(en_cnt),
                            32'(exp_q[0].n_en));
                        if (exp_q[0].n_en > 0) begin
                            chk({exp_q[0].nm, "_we"}, 32'(f_we), 32'(exp_q[0].we));
                            chk({exp_q[0].nm, "_addr"}, f_addr, exp_q[0].addr);
                        end
                        void'(exp_q.pop_front());
                        en_cnt = 0;
                        seen   = 1'b0;
                    end
                end
            end
        end
    end

    // Driver: called at posedge+1; returns at posedge+1 after the accept edge
    task automatic issue(input string nm, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BN-1:0] s,
                         input logic [DW-1:0] erd, input logic eerr,
                         input int elat, input int nen);
        exp_t e;
        int   k;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            chk({nm, "_accept_timeout"}, 32'd1, 32'd0);
            cmd_valid = 1'b0;
            return;
        end
        e.nm    = nm;
        e.rdata = erd;
        e.err   = eerr;
        e.lat   = elat;
        e.acc   = cyc + 1;
        e.n_en  = nen;
        e.we    = wr ? s : '0;
        e.addr  = a;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [AW-1:0] a,
                      input logic [DW-1:0] x);
        issue(nm, 1'b0, a, '0, '0, x, 1'b0, 2 + LAT, 1);
    endtask

    task automatic wr(input string nm, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [BN-1:0] s,
                      input logic [DW-1:0] after);
        issue(nm, 1'b1, a, d, s, VER ? after : '0, 1'b0,
              VER ? 3 + LAT : 2, VER ? 2 : 1);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_bram_en", 32'(bram_en), 32'd0);
        chk("rst_bram_we", 32'(bram_we), 32'd0);
        chk("rst_bram_addr", bram_addr, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        wr("wr_full", 32'h4, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF);
        rd("rd_back", 32'h4, 32'hDEAD_BEEF);
        issue("rd_unaligned", 1'b0, 32'h6, '0, '0, '0, 1'b1, 1, 0);
        issue("wr_nostrb", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, '0, 1'b0, 1, 0);
        issue("wr_unaligned", 1'b1, 32'h5, '0, 4'hF, '0, 1'b1, 1, 0);
        rd("rd_keep", 32'h4, 32'hDEAD_BEEF);
        rd("rd_nostrb", 32'h10, 32'h0);
        wr("wr_w8", 32'h8, 32'h1122_3344, 4'hF, 32'h1122_3344);
        wr("wr_part", 32'h8, 32'hAABB_CCDD, 4'h6, 32'h11BB_CC44);
        rd("rd_part", 32'h8, 32'h11BB_CC44);
        wr("wr_top", 32'h3C, 32'h0F0F_0F0F, 4'h8, 32'h0F00_0000);
        rd("rd_top", 32'h3C, 32'h0F00_0000);
        drain();

        rsp_ready = 1'b0;
        rd("rd_stall", 32'h4, 32'hDEAD_BEEF);
        fork
            wr("wr_after_stall", 32'hC, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D);
            begin
                repeat (2 + LAT + 5) @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        rd("rd_after_stall", 32'hC, 32'hCAFE_F00D);
        drain();

`ifdef SYS_CFG_MST_WR_VERIFY_EN
        ignore_lane0 = 1'b1;
        issue("vfy_bad", 1'b1, 32'h20, 32'h1234_5678, 4'h3, 32'h0000_5600,
              1'b1, 3 + LAT, 2);
        drain();
        ignore_lane0 = 1'b0;
        issue("vfy_good", 1'b1, 32'h20, 32'h1234_5678, 4'h3, 32'h0000_5678,
              1'b0, 3 + LAT, 2);
        drain();
`endif

        issue("rd_abort", 1'b0, 32'h4, '0, '0, '0, 1'b0, 0, 0);
        rstn = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_bram_en", 32'(bram_en), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("abort_rsp_rdata", rsp_rdata, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort_rel_rsp_valid", 32'(rsp_valid), 32'd0);
        rd("rd_after_abort", 32'h8, 32'h11BB_CC44);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, %0d pending", exp_q.size());
        $fatal(1, "watchdog");
    end

endmodule
